multdiv_unit: RTL

Parametrised multi-cycle signed multiply/divide unit for the pipelined processor. It sits beside the execute stage. Execute hands it an operation through a valid/ready handshake, and it returns the result and destination tag through a second valid/ready handshake. Execute stalls issue while `busy` is high. It generalises the single-cycle ALU path with configurable width, tag passthrough, backpressure, flush and exception reporting.

---
 rtl/multdiv_unit.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/multdiv_unit.sv
// rtl/multdiv_unit.sv - multi-cycle signed multiply/divide unit with tag passthrough
// Define MULTDIV_DIV_EN to build the restoring divider; otherwise divide requests finish with an exception.
module multdiv_unit #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [TAG_W-1:0] tag_in,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] tag_out,
  output logic             exception,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   operandMag;
  logic               negResult;
  logic               quickReg;
  logic [TAG_W-1:0]   tagReg;

  logic               accept;
  logic               quickFinish;
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulNext;
  logic [2*WIDTH-1:0] signedFull;
  logic [2*WIDTH-1:0] stepNext;
  logic [WIDTH-1:0]   finalResult;
  logic               finalExc;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  always_comb begin
    start_ready = reset && !flush && (state == IDLE || (state == DONE && result_ready));
  end

  assign accept = start_valid && start_ready;

`ifdef MULTDIV_DIV_EN
  logic               isDiv;
  logic [WIDTH-1:0]   divShift;
  logic [WIDTH:0]     divDiff;
  logic [2*WIDTH-1:0] divNext;

  assign quickFinish = op && (operand_b == '0);
`else
  assign quickFinish = op;
`endif

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}; both shift right/left one bit per edge
  always_comb begin
    mulSum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operandMag};
    mulNext     = acc[0] ? {mulSum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:1]};
    signedFull  = negResult ? -mulNext : mulNext;
    stepNext    = mulNext;
    finalResult = signedFull[WIDTH-1:0];
    finalExc    = signedFull[2*WIDTH-1:WIDTH] != {WIDTH{signedFull[WIDTH-1]}};
`ifdef MULTDIV_DIV_EN
    // Remainder stays below the divisor magnitude, so its top bit is always clear before the shift
    divShift = {acc[2*WIDTH-2:WIDTH], acc[WIDTH-1]};
    divDiff  = {1'b0, divShift} - {1'b0, operandMag};
    divNext  = divDiff[WIDTH] ? {divShift, acc[WIDTH-2:0], 1'b0}
                              : {divDiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    if (isDiv) begin
      stepNext    = divNext;
      finalResult = negResult ? -divNext[WIDTH-1:0] : divNext[WIDTH-1:0];
      finalExc    = !negResult && divNext[WIDTH-1];
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      count        <= '0;
      acc          <= '0;
      operandMag   <= '0;
      negResult    <= 1'b0;
      quickReg     <= 1'b0;
      tagReg       <= '0;
      result       <= '0;
      tag_out      <= '0;
      exception    <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
`ifdef MULTDIV_DIV_EN
      isDiv        <= 1'b0;
`endif
    end else if (flush) begin
      state        <= IDLE;
      count        <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else if (accept) begin
      state        <= RUN;
      count        <= '0;
      acc          <= {{WIDTH{1'b0}}, magnitude(operand_a)};
      operandMag   <= magnitude(operand_b);
      negResult    <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
      quickReg     <= quickFinish;
      tagReg       <= tag_in;
      result_valid <= 1'b0;
      busy         <= 1'b1;
`ifdef MULTDIV_DIV_EN
      isDiv        <= op;
`endif
    end else begin
      case (state)
        RUN: begin
          if (quickReg) begin
            state        <= DONE;
            result       <= '0;
            exception    <= 1'b1;
            tag_out      <= tagReg;
            result_valid <= 1'b1;
          end else begin
            acc   <= stepNext;
            count <= count + CNT_W'(1);
            if (count == LAST) begin
              state        <= DONE;
              result       <= finalResult;
              exception    <= finalExc;
              tag_out      <= tagReg;
              result_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (result_ready) begin
            state        <= IDLE;
            result_valid <= 1'b0;
            busy         <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
